// File: rtl/osd_wr_arbiter_pkg.sv
// Shared constants and types for the OSD write-port arbiter.
package osd_wr_arbiter_pkg;

  localparam int unsigned OSD_WR_W       = 23;
  localparam int unsigned OSD_WR_TOG_BIT = 1;
  localparam int unsigned OSD_WR_SEL_BIT = 0;

  localparam logic OSD_SEL_TEXT = 1'b0;
  localparam logic OSD_SEL_ATTR = 1'b1;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_HW  = 1'b1
  } grant_t;

endpackage

// File: rtl/osd_wr_fifo.sv
// Small synchronous FIFO buffering CPU writes that cannot be back-pressured.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module osd_wr_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; reset discards any buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/osd_wr_arbiter.sv
// Round-robin arbiter sharing the OSD RAM write port between the CPU PIO
// write vector (toggle-strobed, FIFO-buffered) and a valid/ready HW writer.
module osd_wr_arbiter
  import osd_wr_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WR_W       = OSD_WR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      cpu_wrctrl_i,
  input  logic [WR_W-1:0] cpu_wrdata_i,
  input  logic            hw_valid_i,
  input  logic            hw_sel_i,
  input  logic [WR_W-1:0] hw_data_i,
  output logic            hw_ready_o,
  input  logic            hold_i,
  input  logic            ovf_clr_i,
  output logic            osd_we_o,
  output logic            osd_sel_o,
  output logic [WR_W-1:0] osd_data_o,
  output logic            ovf_o
);

  logic          tog_q;
  logic          cpu_event;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [WR_W:0] fifo_din;
  logic [WR_W:0] fifo_dout;
  logic          grant_cpu;
  logic          grant_hw;
  logic          contended;
  logic          overflow;
  grant_t        last_grant;

  assign cpu_event = (cpu_wrctrl_i[OSD_WR_TOG_BIT] != tog_q) && !rst;
  assign fifo_din  = {cpu_wrctrl_i[OSD_WR_SEL_BIT], cpu_wrdata_i};

  // A full FIFO still accepts a write when its head leaves in the same cycle.
  assign fifo_push = cpu_event && (!fifo_full || grant_cpu);
  assign overflow  = cpu_event && fifo_full && !grant_cpu;

  assign contended  = !rst && !hold_i && !fifo_empty && hw_valid_i;
  assign hw_ready_o = grant_hw;

  osd_wr_fifo #(
    .WIDTH (WR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (grant_cpu),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Toggle history tracks the strobe even in reset so release creates no event.
  always_ff @(posedge clk) begin
    tog_q <= cpu_wrctrl_i[OSD_WR_TOG_BIT];
  end

  // Grant decision; nothing is granted during reset or the readout window.
  always_comb begin
    grant_cpu = 1'b0;
    grant_hw  = 1'b0;
    if (!rst && !hold_i) begin
      if (contended) begin
        if (last_grant == GRANT_HW) begin
          grant_cpu = 1'b1;
        end else begin
          grant_hw = 1'b1;
        end
      end else if (!fifo_empty) begin
        grant_cpu = 1'b1;
      end else if (hw_valid_i) begin
        grant_hw = 1'b1;
      end
    end
  end

  // Round-robin memory, advanced only when both requesters compete.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_HW;
    end else if (contended) begin
      last_grant <= grant_hw ? GRANT_HW : GRANT_CPU;
    end
  end

  // Registered write port towards the OSD RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      osd_we_o   <= 1'b0;
      osd_sel_o  <= OSD_SEL_TEXT;
      osd_data_o <= '0;
    end else if (grant_cpu) begin
      osd_we_o   <= 1'b1;
      osd_sel_o  <= fifo_dout[WR_W];
      osd_data_o <= fifo_dout[WR_W-1:0];
    end else if (grant_hw) begin
      osd_we_o   <= 1'b1;
      osd_sel_o  <= hw_sel_i;
      osd_data_o <= hw_data_i;
    end else begin
      osd_we_o <= 1'b0;
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o <= 1'b0;
    end else if (overflow) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_osd_wr_arbiter.sv
// Self-checking bench for osd_wr_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_osd_wr_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 23;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   cpu_wrctrl;
  logic [W-1:0] cpu_wrdata;
  logic         hw_valid;
  logic         hw_sel;
  logic [W-1:0] hw_data;
  logic         hw_ready;
  logic         hold;
  logic         ovf_clr;
  logic         osd_we;
  logic         osd_sel;
  logic [W-1:0] osd_data;
  logic         ovf;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [W:0]   q[$];
  logic         m_tog;
  logic         m_last_hw;
  logic         m_ready;
  logic         e_we;
  logic         e_sel;
  logic [W-1:0] e_data;
  logic         e_ovf;

  osd_wr_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .WR_W       (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_wrctrl_i (cpu_wrctrl),
    .cpu_wrdata_i (cpu_wrdata),
    .hw_valid_i   (hw_valid),
    .hw_sel_i     (hw_sel),
    .hw_data_i    (hw_data),
    .hw_ready_o   (hw_ready),
    .hold_i       (hold),
    .ovf_clr_i    (ovf_clr),
    .osd_we_o     (osd_we),
    .osd_sel_o    (osd_sel),
    .osd_data_o   (osd_data),
    .ovf_o        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the reference: decide the grant from pending work, then
  // move entries between the queue and the expected output.
  task automatic model_step();
    logic ev, a, b, gc, gh, full, ovf_now;
    logic [W:0] ent;
    if (rst) begin
      q.delete();
      e_we = 1'b0; e_sel = 1'b0; e_data = '0; e_ovf = 1'b0;
      m_last_hw = 1'b1;
      m_tog = cpu_wrctrl[1];
      m_ready = 1'b0;
    end else begin
      ev = (cpu_wrctrl[1] != m_tog);
      m_tog = cpu_wrctrl[1];
      a = (q.size() != 0);
      b = hw_valid;
      gc = 1'b0;
      gh = 1'b0;
      if (!hold) begin
        if (a && b) begin
          if (m_last_hw) gc = 1'b1;
          else gh = 1'b1;
          m_last_hw = gh;
        end else if (a) begin
          gc = 1'b1;
        end else if (b) begin
          gh = 1'b1;
        end
      end
      m_ready = gh;
      full = (q.size() == DEPTH);
      e_we = gc | gh;
      if (gc) begin
        ent = q.pop_front();
        e_sel = ent[W];
        e_data = ent[W-1:0];
      end
      if (gh) begin
        e_sel = hw_sel;
        e_data = hw_data;
      end
      ovf_now = ev && full && !gc;
      if (ev && !ovf_now) q.push_back({cpu_wrctrl[0], cpu_wrdata});
      if (ovf_now) e_ovf = 1'b1;
      else if (ovf_clr) e_ovf = 1'b0;
    end
  endtask

  // Inputs are set by the caller near the falling edge; this checks the
  // combinational ready, clocks once and checks the registered outputs.
  task automatic tick();
    #1;
    model_step();
    check_eq("hw_ready", {31'd0, hw_ready}, {31'd0, m_ready});
    @(posedge clk);
    #1;
    check_eq("osd_we",   {31'd0, osd_we},  {31'd0, e_we});
    check_eq("osd_sel",  {31'd0, osd_sel}, {31'd0, e_sel});
    check_eq("osd_data", {9'd0, osd_data}, {9'd0, e_data});
    check_eq("ovf",      {31'd0, ovf},     {31'd0, e_ovf});
    @(negedge clk);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(input logic sel, input logic [W-1:0] data);
    cpu_wrctrl = {~cpu_wrctrl[1], sel};
    cpu_wrdata = data;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_wrctrl = 2'b10;
    cpu_wrdata = '0;
    hw_valid = 1'b0;
    hw_sel = 1'b0;
    hw_data = '0;
    hold = 1'b0;
    ovf_clr = 1'b0;
    m_tog = 1'b0;
    m_last_hw = 1'b1;
    m_ready = 1'b0;
    e_we = 1'b0; e_sel = 1'b0; e_data = '0; e_ovf = 1'b0;
    @(negedge clk);

    // 1: reset with strobe high, release, no spurious write
    ticks(3);
    rst = 1'b0;
    ticks(10);
    check_eq("t1_ovf", {31'd0, ovf}, 32'd0);

    // 2: single uncontended CPU write appears two edges later
    cpu_write(1'b1, 23'h12345);
    check_eq("t2_we_early", {31'd0, osd_we}, 32'd0);
    tick();
    check_eq("t2_we", {31'd0, osd_we}, 32'd1);
    check_eq("t2_data", {9'd0, osd_data}, 32'h12345);
    ticks(4);

    // 3: two CPU entries against a permanent HW request
    do_reset();
    hold = 1'b1;
    cpu_write(1'b0, 23'h00111);
    cpu_write(1'b1, 23'h00222);
    hw_valid = 1'b1;
    hw_sel = 1'b0;
    hw_data = 23'h00AAA;
    hold = 1'b0;
    ticks(6);
    hw_valid = 1'b0;
    ticks(2);

    // 4: five writes during hold overflow a four-entry FIFO
    do_reset();
    hold = 1'b1;
    for (int unsigned i = 0; i < 5; i++) cpu_write(i[0], 23'h40000 + W'(i));
    tick();
    check_eq("t4_ovf", {31'd0, ovf}, 32'd1);
    hold = 1'b0;
    ticks(7);

    // 5: clear colliding with a fresh overflow, then clear alone
    hold = 1'b1;
    for (int unsigned i = 0; i < 4; i++) cpu_write(1'b0, 23'h50000 + W'(i));
    ovf_clr = 1'b1;
    cpu_write(1'b1, 23'h5FFFF);
    check_eq("t5_ovf_set_wins", {31'd0, ovf}, 32'd1);
    tick();
    check_eq("t5_ovf_cleared", {31'd0, ovf}, 32'd0);
    ovf_clr = 1'b0;
    hold = 1'b0;
    ticks(6);

    // 6: reset while three entries are buffered
    hold = 1'b1;
    for (int unsigned i = 0; i < 3; i++) cpu_write(1'b1, 23'h60000 + W'(i));
    hold = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("t6_we_after_rst", {31'd0, osd_we}, 32'd0);
    rst = 1'b0;
    ticks(8);

    // Random traffic
    for (int unsigned c = 0; c < 1500; c++) begin
      if ($urandom_range(2) == 0) begin
        cpu_wrctrl = {~cpu_wrctrl[1], 1'($urandom)};
        cpu_wrdata = W'($urandom);
      end
      hw_valid = 1'($urandom);
      hw_sel = 1'($urandom);
      hw_data = W'($urandom);
      hold = ($urandom_range(3) == 0);
      ovf_clr = ($urandom_range(15) == 0);
      rst = ($urandom_range(149) == 0);
      tick();
    end
    rst = 1'b0;
    hold = 1'b0;
    hw_valid = 1'b0;
    ticks(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
